// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions: data width, entry bit positions and the entry layout.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int PAR_BIT     = UART_DATA_W;
  localparam int FRM_BIT     = UART_DATA_W + 1;

  typedef struct packed {
    logic                   frame_err;
    logic                   parity_err;
    logic [UART_DATA_W-1:0] data;
  } uart_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage array: registered write port, asynchronous read port.
module uart_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 10,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port; contents are intentionally left unreset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with sticky overflow.
// Define UART_RX_FIFO_DROP_ERR_EN to discard errored frames and count them on err_drop_cnt.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int    DATA_W = UART_DATA_W,
  parameter int    DEPTH  = 16,
  localparam int   ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done_tick,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_parity_err,
  input  logic              rx_frame_err,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_parity_err,
  output logic              dout_frame_err,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_overflow
`ifdef UART_RX_FIFO_DROP_ERR_EN
  ,
  output logic [7:0]        err_drop_cnt
`endif
);

  localparam int              ENTRY_W  = DATA_W + 2;
  localparam int              PAR_POS  = PAR_BIT + DATA_W - UART_DATA_W;
  localparam int              FRM_POS  = FRM_BIT + DATA_W - UART_DATA_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0]  wr_ptr_r;
  logic [ADDR_W-1:0]  rd_ptr_r;
  logic [ADDR_W:0]    count_r;
  logic               overflow_r;
  logic               empty_s;
  logic               full_s;
  logic               drop_s;
  logic               accept_s;
  logic               wr_s;
  logic               rd_s;
  logic               ovf_set_s;
  logic [ENTRY_W-1:0] wr_entry_s;
  logic [ENTRY_W-1:0] rd_entry_s;

`ifdef UART_RX_FIFO_DROP_ERR_EN
  logic [7:0] err_cnt_r;
  assign drop_s       = rx_done_tick & (rx_parity_err | rx_frame_err);
  assign err_drop_cnt = err_cnt_r;
`else
  assign drop_s = 1'b0;
`endif

  assign empty_s   = (count_r == '0);
  assign full_s    = (count_r == FULL_CNT);
  assign accept_s  = rx_done_tick & ~drop_s & ~rst;
  // A full FIFO still accepts a write when the head is popped in the same cycle
  assign wr_s      = accept_s & (~full_s | rd_en);
  assign rd_s      = rd_en & ~empty_s;
  assign ovf_set_s = accept_s & full_s & ~rd_en;

  // Pack the incoming frame into {frame_err, parity_err, data}
  always_comb begin
    wr_entry_s               = '0;
    wr_entry_s[DATA_W-1:0]   = rx_data;
    wr_entry_s[PAR_POS]      = rx_parity_err;
    wr_entry_s[FRM_POS]      = rx_frame_err;
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .WIDTH  (ENTRY_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_s),
    .waddr (wr_ptr_r),
    .wdata (wr_entry_s),
    .raddr (rd_ptr_r),
    .rdata (rd_entry_s)
  );

  // Pointer, occupancy and sticky overflow state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
      end
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + (ADDR_W+1)'(1);
        2'b01:   count_r <= count_r - (ADDR_W+1)'(1);
        default: count_r <= count_r;
      endcase
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (clr_overflow) begin
        overflow_r <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FIFO_DROP_ERR_EN
  // Saturating count of discarded errored frames
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_r <= 8'd0;
    end else if (drop_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end
`endif

  // Head entry falls through; outputs read as zero while empty
  always_comb begin
    if (empty_s) begin
      dout            = '0;
      dout_parity_err = 1'b0;
      dout_frame_err  = 1'b0;
    end else begin
      dout            = rd_entry_s[DATA_W-1:0];
      dout_parity_err = rd_entry_s[PAR_POS];
      dout_frame_err  = rd_entry_s[FRM_POS];
    end
  end

  assign count    = count_r;
  assign empty    = empty_s;
  assign full     = full_s;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, DATA_W=8).
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rd_en;
  logic [7:0] dout;
  logic       dout_parity_err;
  logic       dout_frame_err;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       clr_overflow;
`ifdef UART_RX_FIFO_DROP_ERR_EN
  logic [7:0] err_drop_cnt;
`endif

  int n_checks;
  int n_errors;

  uart_rx_fifo dut (
    .clk             (clk),
    .rst             (rst),
    .rx_done_tick    (rx_done_tick),
    .rx_data         (rx_data),
    .rx_parity_err   (rx_parity_err),
    .rx_frame_err    (rx_frame_err),
    .rd_en           (rd_en),
    .dout            (dout),
    .dout_parity_err (dout_parity_err),
    .dout_frame_err  (dout_frame_err),
    .empty           (empty),
    .full            (full),
    .count           (count),
    .overflow        (overflow),
    .clr_overflow    (clr_overflow)
`ifdef UART_RX_FIFO_DROP_ERR_EN
    ,
    .err_drop_cnt    (err_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    rx_done_tick  = 1'b1;
    rx_data       = d;
    rx_parity_err = pe;
    rx_frame_err  = fe;
    tick();
    rx_done_tick  = 1'b0;
    rx_parity_err = 1'b0;
    rx_frame_err  = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic push_pop(input logic [7:0] d);
    rx_done_tick = 1'b1;
    rx_data      = d;
    rd_en        = 1'b1;
    tick();
    rx_done_tick = 1'b0;
    rd_en        = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_d [3];
    logic       exp_p [3];
    logic       exp_f [3];
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    rx_done_tick  = 1'b0;
    rx_data       = 8'h00;
    rx_parity_err = 1'b0;
    rx_frame_err  = 1'b0;
    rd_en         = 1'b0;
    clr_overflow  = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_full", 32'(full), 32'd0);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    check_val("rst_dout", {21'd0, dout_frame_err, dout_parity_err, dout}, 32'd0);
`ifdef UART_RX_FIFO_DROP_ERR_EN
    check_val("rst_err_cnt", 32'(err_drop_cnt), 32'd0);
`endif

    // Single write then read
    push(8'hA5, 1'b0, 1'b0);
    check_val("wr1_empty", 32'(empty), 32'd0);
    check_val("wr1_count", 32'(count), 32'd1);
    check_val("wr1_dout", 32'(dout), 32'hA5);
    pop();
    check_val("rd1_empty", 32'(empty), 32'd1);
    check_val("rd1_dout", 32'(dout), 32'd0);

    // Read while empty is ignored
    pop();
    check_val("rd_empty_count", 32'(count), 32'd0);

    // Write and read together while empty: write wins, count becomes 1
    push_pop(8'h3C);
    check_val("wr_rd_empty_count", 32'(count), 32'd1);
    check_val("wr_rd_empty_dout", 32'(dout), 32'h3C);
    pop();

`ifndef UART_RX_FIFO_DROP_ERR_EN
    // Flags travel with their data
    exp_d[0] = 8'h11; exp_p[0] = 1'b0; exp_f[0] = 1'b0;
    exp_d[1] = 8'h22; exp_p[1] = 1'b1; exp_f[1] = 1'b0;
    exp_d[2] = 8'h33; exp_p[2] = 1'b0; exp_f[2] = 1'b1;
    for (int i = 0; i < 3; i++) push(exp_d[i], exp_p[i], exp_f[i]);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("flag_dout%0d", i), 32'(dout), 32'(exp_d[i]));
      check_val($sformatf("flag_par%0d", i), 32'(dout_parity_err), 32'(exp_p[i]));
      check_val($sformatf("flag_frm%0d", i), 32'(dout_frame_err), 32'(exp_f[i]));
      pop();
    end
    check_val("flag_empty", 32'(empty), 32'd1);
`else
    // Errored frames are discarded and counted
    push(8'h55, 1'b0, 1'b1);
    check_val("drop_count0", 32'(count), 32'd0);
    push(8'h66, 1'b0, 1'b0);
    check_val("drop_count1", 32'(count), 32'd1);
    check_val("drop_dout", 32'(dout), 32'h66);
    check_val("drop_cnt1", 32'(err_drop_cnt), 32'd1);
    pop();
    for (int i = 0; i < 300; i++) push(8'(i), 1'b1, 1'b0);
    check_val("drop_cnt_sat", 32'(err_drop_cnt), 32'd255);
    check_val("drop_keep_empty", 32'(empty), 32'd1);
    check_val("drop_no_ovf", 32'(overflow), 32'd0);
`endif

    // Fill to full, then overflow
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i), 1'b0, 1'b0);
    check_val("fill_full", 32'(full), 32'd1);
    check_val("fill_count", 32'(count), 32'd16);
    check_val("fill_ovf", 32'(overflow), 32'd0);
    push(8'hFF, 1'b0, 1'b0);
    check_val("ovf_set", 32'(overflow), 32'd1);
    check_val("ovf_count", 32'(count), 32'd16);
    check_val("ovf_head", 32'(dout), 32'h40);
    pop();
    check_val("ovf_sticky", 32'(overflow), 32'd1);
    check_val("ovf_pop_count", 32'(count), 32'd15);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check_val("ovf_clr", 32'(overflow), 32'd0);

    // Set beats clear in the same cycle
    push(8'h50, 1'b0, 1'b0);
    clr_overflow = 1'b1;
    push(8'hFE, 1'b0, 1'b0);
    clr_overflow = 1'b0;
    check_val("ovf_set_prio", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check_val("ovf_clr2", 32'(overflow), 32'd0);

    // Write and read together while full
    push_pop(8'h77);
    check_val("full_wr_rd_count", 32'(count), 32'd16);
    check_val("full_wr_rd_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check_val($sformatf("drain%0d", i), 32'(dout), (i < 15) ? 32'h42 + 32'(i) : 32'h77);
      pop();
    end
    check_val("drain_empty", 32'(empty), 32'd1);

    // Streaming through 40 entries to wrap both pointers
    push(8'h80, 1'b0, 1'b0);
    for (int i = 1; i < 40; i++) begin
      check_val($sformatf("stream%0d", i), 32'(dout), 32'h80 + 32'(i - 1));
      push_pop(8'h80 + 8'(i));
    end
    check_val("stream_count", 32'(count), 32'd1);
    check_val("stream_last", 32'(dout), 32'hA7);
    pop();

    // Reset mid-stream discards queued entries and a concurrent write
    push(8'hD1, 1'b0, 1'b0);
    push(8'hD2, 1'b0, 1'b0);
    push(8'hD3, 1'b0, 1'b0);
    rst          = 1'b1;
    rx_done_tick = 1'b1;
    rx_data      = 8'hEE;
    tick();
    rst          = 1'b0;
    rx_done_tick = 1'b0;
    check_val("mid_rst_count", 32'(count), 32'd0);
    check_val("mid_rst_empty", 32'(empty), 32'd1);
    check_val("mid_rst_dout", 32'(dout), 32'd0);
    push(8'h5A, 1'b0, 1'b0);
    check_val("post_rst_dout", 32'(dout), 32'h5A);
    check_val("post_rst_count", 32'(count), 32'd1);
    pop();
    check_val("post_rst_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer placed directly downstream of the UART receiver. Each `rx_done_tick` pulse captures the received byte and its parity and frame error flags into one FIFO entry. The host side reads entries through a first-word-fall-through interface. Overflow is reported as a sticky flag, so the receiver never stalls and no loss goes unnoticed.

Parameters:
- DATA_W, 8, width of the received data word (matches the receiver's N_BIT).
- DEPTH, 16, number of entries; must be a power of 2, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_done_tick  in  1  one-cycle write strobe from the receiver.
- rx_data  in  DATA_W  received byte; valid when rx_done_tick=1.
- rx_parity_err  in  1  parity error flag; sampled with rx_done_tick.
- rx_frame_err  in  1  frame error flag; sampled with rx_done_tick.
- rd_en  in  1  pop request for the head entry.
- dout  out  DATA_W  head entry data; forced to 0 when empty.
- dout_parity_err  out  1  head entry parity flag; 0 when empty.
- dout_frame_err  out  1  head entry frame flag; 0 when empty.
- empty  out  1  no entries held.
- full  out  1  DEPTH entries held.
- count  out  ADDR_W+1  number of entries held, 0..DEPTH.
- overflow  out  1  sticky: a write was lost because the FIFO was full.
- clr_overflow  in  1  clears overflow.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset values:
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, overflow=0.
  - dout, dout_parity_err and dout_frame_err all 0.
  - Memory contents are not reset.
- Entry format: {frame_err, parity_err, data}, DATA_W+2 bits wide.
- Write (wr = rx_done_tick & ~full, or rx_done_tick & full & rd_en):
  - Store the entry at mem[wr_ptr].
  - wr_ptr increments, wrapping modulo DEPTH.
- Read (rd = rd_en & ~empty):
  - rd_ptr increments, wrapping modulo DEPTH.
  - A read when empty is ignored: no pointer movement, no error.
- Outputs are first-word-fall-through:
  - dout and both flags combinationally reflect mem[rd_ptr] whenever empty=0.
  - Latency from write edge to data visible is one cycle: empty falls on the edge that performs the write.
- Count update:
  - count increases by 1 on a write-only cycle.
  - count decreases by 1 on a read-only cycle.
  - count is unchanged when write and read happen together.
- Status decode: empty = (count==0), full = (count==DEPTH). Both are registered or decoded from the registered count, never from the inputs.
- Simultaneous events:
  - Write and read while empty: the write occurs, the read is ignored, and count becomes 1.
  - Write and read while full: both occur, count stays DEPTH, no overflow.
  - Write while full without a read: the entry is dropped, pointers are unchanged, and overflow is set on the next edge.
- overflow:
  - Set has priority over clr_overflow in the same cycle.
  - Otherwise clr_overflow=1 clears it.
- Reset mid-operation: all queued entries are discarded immediately. An rx_done_tick in the same cycle as rst is ignored.

Optional Feature:
- Macro: UART_RX_FIFO_DROP_ERR_EN.
- When defined:
  - Entries with rx_parity_err or rx_frame_err set are not stored.
  - Each such drop increments an added 8-bit output err_drop_cnt, which saturates at 255 and resets to 0.
  - Dropped errored frames never set overflow, even when the FIFO is full.
- When undefined: every frame is stored with its flags, and the err_drop_cnt port does not exist.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W=8.
  - Entry bit-position constants: PAR_BIT=DATA_W, FRM_BIT=DATA_W+1.
  - A typedef for the FIFO entry.
- One sub-module, uart_fifo_mem:
  - Simple dual-port array with registered write and asynchronous read.
  - Parameterised by depth and width.
- Pointers, count, flags and the optional error counter live in the top level.

Test Plan:
- Reset, then write 0xA5 (no errors) → the next cycle shows empty=0, count=1, dout=0xA5. Pulse rd_en → empty=1, dout=0.
- Write 0x11, 0x22 (parity_err=1), 0x33 (frame_err=1), then read three times → data in order, with flags (0,0), (1,0), (0,1).
- Write 16 entries → full=1, count=16. A 17th write 0xFF is dropped and overflow=1. Read → first entry returned; overflow persists until clr_overflow.
- With full=1, apply rx_done_tick and rd_en in the same cycle → count stays 16, overflow stays 0, and the new entry is read last.
- Write and read repeatedly for 40 entries → pointers wrap with no data corruption. Apply rst mid-stream → count=0, empty=1, and entries queued before rst are never output.
- With UART_RX_FIFO_DROP_ERR_EN defined, write 0x55 with frame_err=1, then 0x66 clean → only 0x66 is stored and err_drop_cnt=1. After 300 errored frames, err_drop_cnt=255.
